// File: rtl/led_scan_decoder.sv
// led_scan_decoder
//
// Receive-side monitor for a multiplexed 4-digit seven-segment bus. The bus is
// synchronized and glitch-filtered. Each accepted digit is decoded from its
// active-low segment pattern back to a hex nibble, and the digit scan order is
// checked. Complete in-order frames are then reassembled into a 16-bit value.
//
// Ports:
//   CLOCK_IN     system clock, rising edge
//   reset        asynchronous, active-low
//   LED_BUS      [11:4] = {dp,g,f,e,d,c,b,a} active-low, [3:0] = digit select active-low
//   DATA         last complete valid frame (digit0 in [15:12])
//   DP           decimal points, 1 = lit (digit0 in [3])
//   FRAME_VALID  one-cycle pulse, DATA/DP updated in the same cycle
//   CODE_ERR     one-cycle pulse, in-order frame held an undecodable pattern
//   SEQ_ERR      one-cycle pulse, accepted digit out of scan order
//   ACTIVE       high while a frame is being acquired
//   FRAME_CNT    count of valid frames, wraps
module led_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLOCK_IN,
    input  logic        reset,
    input  logic [11:0] LED_BUS,
    output logic [15:0] DATA,
    output logic [3:0]  DP,
    output logic        FRAME_VALID,
    output logic        CODE_ERR,
    output logic        SEQ_ERR,
    output logic        ACTIVE,
    output logic [7:0]  FRAME_CNT
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {HUNT = 1'b0, ACQ = 1'b1} state_t;

    // {valid, nibble} for a {g..a} pattern
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40: r = 5'h10;
            7'h79: r = 5'h11;
            7'h24: r = 5'h12;
            7'h30: r = 5'h13;
            7'h19: r = 5'h14;
            7'h12: r = 5'h15;
            7'h02: r = 5'h16;
            7'h78: r = 5'h17;
            7'h00: r = 5'h18;
            7'h10: r = 5'h19;
            7'h08: r = 5'h1A;
            7'h03: r = 5'h1B;
            7'h27: r = 5'h1C;
            7'h21: r = 5'h1D;
            7'h06: r = 5'h1E;
            7'h0E: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // {legal, digit index}; legal only when exactly one select bit is low
    function automatic logic [2:0] sel_index(input logic [3:0] sel);
        logic [2:0] r;
        case (sel)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [11:0] sync_p0, sync_p1, last_p2, acc_bus_p3;
    logic [7:0]  cnt_p2;
    logic        acc_vld_p3;

    // synchronizer stages
    always_ff @(posedge CLOCK_IN or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= LED_BUS;
            sync_p1 <= sync_p0;
        end
    end

    // stability filter: counter saturates at STABLE so a long dwell accepts once
    always_ff @(posedge CLOCK_IN or negedge reset) begin
        if (!reset) begin
            last_p2    <= '0;
            cnt_p2     <= '0;
            acc_vld_p3 <= 1'b0;
            acc_bus_p3 <= '0;
        end else begin
            last_p2    <= sync_p1;
            acc_bus_p3 <= sync_p1;
            acc_vld_p3 <= (sync_p1 == last_p2) && (cnt_p2 == STABLE - 8'd1);
            if (sync_p1 != last_p2)
                cnt_p2 <= 8'd1;
            else if (cnt_p2 != STABLE)
                cnt_p2 <= cnt_p2 + 8'd1;
        end
    end

    // frame assembly FSM
    state_t          state, state_n;
    logic [1:0]      expect_q, expect_n;
    logic [3:0][3:0] nib_q, nib_n;
    logic [3:0]      dpl_q, dpl_n, ok_q, ok_n;
    logic [15:0]     data_n;
    logic [3:0]      dpo_n;
    logic [7:0]      cnt_n;
    logic            fv_n, ce_n, se_n;
    logic [2:0]      sel_info;
    logic [4:0]      dec;
    logic [1:0]      idx;

    always_comb begin
        sel_info = sel_index(acc_bus_p3[3:0]);
        dec      = seg_decode(acc_bus_p3[10:4]);
        idx      = sel_info[1:0];
        state_n  = state;
        expect_n = expect_q;
        nib_n    = nib_q;
        dpl_n    = dpl_q;
        ok_n     = ok_q;
        data_n   = DATA;
        dpo_n    = DP;
        cnt_n    = FRAME_CNT;
        fv_n     = 1'b0;
        ce_n     = 1'b0;
        se_n     = 1'b0;
        if (acc_vld_p3 && sel_info[2]) begin
            case (state)
                HUNT: begin
                    if (idx == 2'd0) begin
                        nib_n[0] = dec[3:0];
                        dpl_n[0] = ~acc_bus_p3[11];
                        ok_n[0]  = dec[4];
                        expect_n = 2'd1;
                        state_n  = ACQ;
                    end
                end
                ACQ: begin
                    if (idx == expect_q) begin
                        nib_n[idx] = dec[3:0];
                        dpl_n[idx] = ~acc_bus_p3[11];
                        ok_n[idx]  = dec[4];
                        expect_n   = expect_q + 2'd1;
                        if (idx == 2'd3) begin
                            state_n = HUNT;
                            if (&ok_n) begin
                                fv_n   = 1'b1;
                                data_n = {nib_n[0], nib_n[1], nib_n[2], nib_n[3]};
                                dpo_n  = {dpl_n[0], dpl_n[1], dpl_n[2], dpl_n[3]};
                                cnt_n  = FRAME_CNT + 8'd1;
                            end else begin
                                ce_n = 1'b1;
                            end
                        end
                    end else begin
                        // partial frame dropped; a digit0 restarts immediately
                        se_n  = 1'b1;
                        nib_n = '0;
                        dpl_n = '0;
                        ok_n  = '0;
                        if (idx == 2'd0) begin
                            nib_n[0] = dec[3:0];
                            dpl_n[0] = ~acc_bus_p3[11];
                            ok_n[0]  = dec[4];
                            expect_n = 2'd1;
                        end else begin
                            expect_n = 2'd0;
                            state_n  = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLOCK_IN or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            expect_q    <= '0;
            nib_q       <= '0;
            dpl_q       <= '0;
            ok_q        <= '0;
            DATA        <= '0;
            DP          <= '0;
            FRAME_CNT   <= '0;
            FRAME_VALID <= 1'b0;
            CODE_ERR    <= 1'b0;
            SEQ_ERR     <= 1'b0;
        end else begin
            state       <= state_n;
            expect_q    <= expect_n;
            nib_q       <= nib_n;
            dpl_q       <= dpl_n;
            ok_q        <= ok_n;
            DATA        <= data_n;
            DP          <= dpo_n;
            FRAME_CNT   <= cnt_n;
            FRAME_VALID <= fv_n;
            CODE_ERR    <= ce_n;
            SEQ_ERR     <= se_n;
        end
    end

    assign ACTIVE = (state == ACQ);

endmodule

// File: doc/led_scan_decoder.md
# led_scan_decoder

Receive-side monitor for the multiplexed 4-digit seven-segment bus that the display driver produces: a 12-bit bus carrying segment pattern bits [11:4] and digit select bits [3:0]. It samples the bus and rejects short glitches. It then decodes each active-low segment pattern back to a hex nibble, checks the digit scan order and reassembles the 16-bit displayed value. It sits beside the display driver as an in-system checker and as a loop-back source for self-test.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is accepted; legal range 2..255.
- CLOCK_IN  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- LED_BUS  input  12  monitored bus, asynchronous to CLOCK_IN.
  - [11:4] = {dp,g,f,e,d,c,b,a}, each active-low.
  - [3:0] = digit select, active-low: 1110 = digit0 = DATA[15:12], 1101 = digit1 = [11:8], 1011 = digit2 = [7:4], 0111 = digit3 = [3:0].
- DATA  output  16  last complete valid frame.
- DP  output  4  decimal-point state per digit, 1 = lit; DP[3] = digit0 … DP[0] = digit3.
- FRAME_VALID  output  1  one-cycle pulse; DATA/DP updated in the same cycle.
- CODE_ERR  output  1  one-cycle pulse: frame completed in order but contained an undecodable pattern.
- SEQ_ERR  output  1  one-cycle pulse: an accepted digit arrived out of scan order.
- ACTIVE  output  1  high while in ACQ state.
- FRAME_CNT  output  8  count of valid frames, wraps 255→0.

## Operation
- **Synchronizer.** Two-flop synchronizer on all 12 bits of LED_BUS.
- **Stability filter.**
  - A counter restarts whenever the synchronized value changes.
  - When the value has been identical for STABLE_CYCLES samples, one internal accept strobe is issued.
  - No further accept is issued until the value changes, so a long dwell is accepted exactly once.
- **Select filter.** An accepted value whose select field does not have exactly one zero bit (e.g. 1111 blanking, 1100) is discarded. It has no effect on state.
- **Decode.** Bits [10:4] are compared against the 16 codes below, written as hex values of {g..a}.
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78.
  - 8→00, 9→10, A→08, B→03, C→27, D→21, E→06, F→0E.
  - Any other pattern, including 7F (blank), is invalid.
  - dp is captured as ~LED_BUS[11].
- **FSM, HUNT (reset state).**
  - On an accepted digit0: store its nibble, dp and valid flag; set expected index to 1; go to ACQ.
  - Any other accepted digit is ignored.
- **FSM, ACQ.**
  - Accepted digit == expected: store it and increment expected.
  - If that digit was digit3, the frame ends:
    - If all 4 codes are valid: pulse FRAME_VALID, load DATA/DP, increment FRAME_CNT.
    - Otherwise: pulse CODE_ERR; DATA, DP and FRAME_CNT are unchanged.
    - In both cases return to HUNT.
  - Accepted digit != expected: pulse SEQ_ERR and discard the partial frame.
    - If the offending digit is digit0, restart the frame (stay in ACQ, expected = 1).
    - Otherwise go to HUNT.
- **Simultaneous events.** Only one accept can occur per clock, so events cannot collide. The SEQ_ERR restart and the digit0 capture happen in the same cycle.
- **Reset.** Asserting reset at any time, including mid-frame, asynchronously clears everything:
  - State to HUNT; counters and partial frame cleared.
  - DATA = 0000, DP = 0, FRAME_CNT = 0.
  - FRAME_VALID, CODE_ERR, SEQ_ERR and ACTIVE = 0.

## Timing
- Let k be the first rising edge at which a new LED_BUS value is sampled and then held.
- The accept strobe for that value occurs internally at edge k+STABLE_CYCLES+1.
- All status outputs are registered and update at edge k+STABLE_CYCLES+2. This applies to FRAME_VALID, CODE_ERR, SEQ_ERR, DATA, DP, FRAME_CNT and ACTIVE. With STABLE_CYCLES = 4 this is k+6.
- A value held for fewer than STABLE_CYCLES sampled cycles is never accepted.
- The minimum accepted dwell per digit is STABLE_CYCLES clocks.
- Pulses are exactly one clock wide. At most one of FRAME_VALID, CODE_ERR, SEQ_ERR is high in any cycle.
- ACTIVE rises and falls on the same edge as the corresponding FSM transition.

## Test plan
1. **Valid frame.** STABLE_CYCLES = 4. Drive digit0..3 with patterns F9, A4, 88, 8E (selects 1110, 1101, 1011, 0111), 10 cycles each. Required: one FRAME_VALID, DATA = 0x12AF, DP = 0, FRAME_CNT = 1, ACTIVE low afterwards.
2. **Glitch rejection.** Repeat scenario 1 with a 3-cycle digit2 pattern 0xC0 inserted between digits 0 and 1. Required: no SEQ_ERR; DATA = 0x12AF, FRAME_CNT = 2.
3. **Out-of-order recovery.** Drive digit0, digit2. Required: SEQ_ERR pulse, HUNT. Then drive digit0, digit1, digit2, digit3 (codes 40, 79, 24, 30 with dp lit on digit3). Required: FRAME_VALID, DATA = 0x0123, DP = 0001.
4. **Invalid code.** Drive a frame with digit2 pattern 7F. Required: CODE_ERR pulse only; DATA and FRAME_CNT unchanged.
5. **Blanking and long dwell.** Insert 1111 selects between digits, and hold digit1 for 50 cycles. Required: the frame completes normally with a single acceptance per digit.
6. **Reset and wrap.** Assert reset after digit1 of a frame. Required: all outputs 0, HUNT. Then drive 256 valid frames. Required: FRAME_CNT wraps to 0 on the 256th FRAME_VALID.
